// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client arbiter and sequencer for a shared registered ALU.
// Requests are accepted only in IDLE. Each one is issued to the ALU for one
// cycle, and the result is captured one cycle later. The result is then held
// in the requesting client's response registers until that client accepts it.
// Build option: define ALU_ARB_RR_EN for round-robin tie-breaking. Without it,
// client 0 has fixed priority.
module alu_arbiter #(
    parameter int         WIDTH   = 4,
    parameter logic [1:0] OP_IDLE = 2'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_flag,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_flag,
    output logic [1:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_flag,
    output logic             busy,
    output logic             grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic             grant_q;
    logic [WIDTH-1:0] rsp0_data_q, rsp1_data_q;
    logic             rsp0_flag_q, rsp1_flag_q;

    logic             pick1;
    logic             accept;
    logic             rsp_hs;

`ifdef ALU_ARB_RR_EN
    logic             last_grant_q;

    // Arbitration: a lone requester wins; on a tie the client not granted last time wins
    always_comb begin
        pick1 = req1_valid & (~req0_valid | ~last_grant_q);
    end

    // Round-robin history, reset to 1 so client 0 wins the first tie
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (accept) begin
            last_grant_q <= pick1;
        end
    end
`else
    // Arbitration: client 0 wins whenever it is requesting
    always_comb begin
        pick1 = ~req0_valid;
    end
`endif

    // Acceptance is only possible in IDLE, and it is held off while reset is asserted
    always_comb begin
        accept = (state_q == IDLE) & ~rst & (req0_valid | req1_valid);
        rsp_hs = (state_q == RESP) & (grant_q ? rsp1_ready : rsp0_ready);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> RESP -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = RESP;
            RESP:    if (rsp_hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winning request on acceptance, and capture the ALU result in WAIT
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q        <= OP_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            grant_q     <= 1'b0;
            rsp0_data_q <= '0;
            rsp0_flag_q <= 1'b0;
            rsp1_data_q <= '0;
            rsp1_flag_q <= 1'b0;
        end else begin
            if (accept) begin
                grant_q <= pick1;
                op_q    <= pick1 ? req1_op : req0_op;
                a_q     <= pick1 ? req1_a  : req0_a;
                b_q     <= pick1 ? req1_b  : req0_b;
            end
            if (state_q == WAIT) begin
                if (grant_q) begin
                    rsp1_data_q <= alu_out;
                    rsp1_flag_q <= alu_flag;
                end else begin
                    rsp0_data_q <= alu_out;
                    rsp0_flag_q <= alu_flag;
                end
            end
        end
    end

    // Outputs decoded from the state; operands stay on the ALU bus after the issue cycle
    always_comb begin
        req0_ready = accept & ~pick1;
        req1_ready = accept & pick1;
        alu_op     = (state_q == ISSUE) ? op_q : OP_IDLE;
        alu_a      = a_q;
        alu_b      = b_q;
        busy       = (state_q != IDLE);
        grant      = grant_q;
        rsp0_valid = (state_q == RESP) & ~grant_q;
        rsp1_valid = (state_q == RESP) & grant_q;
        rsp0_data  = rsp0_data_q;
        rsp0_flag  = rsp0_flag_q;
        rsp1_data  = rsp1_data_q;
        rsp1_flag  = rsp1_flag_q;
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: includes a behavioural model of the registered ALU,
// a table of single transactions, and hand-written stall, reset and
// contention sequences.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp1_valid;
    logic       rsp0_ready, rsp1_ready;
    logic [3:0] rsp0_data, rsp1_data;
    logic       rsp0_flag, rsp1_flag;
    logic [1:0] alu_op;
    logic [3:0] alu_a, alu_b;
    logic [3:0] alu_out;
    logic       alu_flag;
    logic       busy, grant;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(4), .OP_IDLE(2'd0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_flag(rsp0_flag),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_flag(rsp1_flag),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_flag(alu_flag),
        .busy(busy), .grant(grant)
    );

    // ALU model: registered op; OFF forces 0/0, NO_OP keeps the previous result,
    // SUB returns |a-b| with the flag set when b > a
    logic [1:0] m_op_q  = 2'd0;
    logic [3:0] m_res_q = 4'd0;
    logic       m_flg_q = 1'b0;
    always @(posedge clk) begin
        m_op_q <= alu_op;
        if (alu_op == 2'd1) begin
            {m_flg_q, m_res_q} <= {1'b0, alu_a} + {1'b0, alu_b};
        end else if (alu_op == 2'd2) begin
            if (alu_a < alu_b) begin
                m_res_q <= alu_b - alu_a;
                m_flg_q <= 1'b1;
            end else begin
                m_res_q <= alu_a - alu_b;
                m_flg_q <= 1'b0;
            end
        end
    end
    assign alu_out  = (m_op_q == 2'd0) ? 4'd0 : m_res_q;
    assign alu_flag = (m_op_q == 2'd0) ? 1'b0 : m_flg_q;

    typedef struct {
        bit         c;
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       f;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_req(input bit c, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        if (!c) begin
            req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Called just after a negedge with the request already driven. Waits (bounded)
    // for ready, lets the acceptance edge pass, then drops valid at the next negedge.
    task automatic accept_req(input bit c, output bit ok);
        int n;
        n  = 0;
        ok = 1'b0;
        #1;
        while (n < 20) begin
            if (c ? req1_ready : req0_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
            #1;
            n++;
        end
        chk("ready timeout", {31'd0, ok}, 32'd1);
        if (ok) begin
            @(posedge clk);
            @(negedge clk);
        end
        if (!c) req0_valid = 1'b0;
        else    req1_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input int idx);
        bit ok;
        int n;
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(negedge clk);
        drive_req(v.c, v.op, v.a, v.b);
        accept_req(v.c, ok);
        if (!ok) return;
        chk({tag, " issue op"}, {30'd0, alu_op}, {30'd0, v.op});
        chk({tag, " issue a"}, {28'd0, alu_a}, {28'd0, v.a});
        n = 0;
        while (!(v.c ? rsp1_valid : rsp0_valid) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " rsp latency"}, n, 32'd2);
        chk({tag, " data"}, {28'd0, v.c ? rsp1_data : rsp0_data}, {28'd0, v.d});
        chk({tag, " flag"}, {31'd0, v.c ? rsp1_flag : rsp0_flag}, {31'd0, v.f});
        chk({tag, " other rsp valid"}, {31'd0, v.c ? rsp0_valid : rsp1_valid}, 32'd0);
        chk({tag, " grant"}, {31'd0, grant}, {31'd0, v.c});
        if (!v.c) rsp0_ready = 1'b1;
        else      rsp1_ready = 1'b1;
        @(negedge clk);
        chk({tag, " valid after hs"}, {31'd0, v.c ? rsp1_valid : rsp0_valid}, 32'd0);
        chk({tag, " busy after hs"}, {31'd0, busy}, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int n;
        int g[4];
        int t[4];
        int ng;
        int cyc;

        vecs[0] = '{c:1'b0, op:2'd1, a:4'h9, b:4'h8, d:4'h1, f:1'b1};
        vecs[1] = '{c:1'b1, op:2'd2, a:4'h3, b:4'h7, d:4'h4, f:1'b1};
        vecs[2] = '{c:1'b1, op:2'd2, a:4'h7, b:4'h3, d:4'h4, f:1'b0};
        vecs[3] = '{c:1'b0, op:2'd1, a:4'h5, b:4'h6, d:4'hB, f:1'b0};
        vecs[4] = '{c:1'b0, op:2'd3, a:4'h0, b:4'h0, d:4'hB, f:1'b0};
        vecs[5] = '{c:1'b1, op:2'd0, a:4'h3, b:4'h4, d:4'h0, f:1'b0};
        vecs[6] = '{c:1'b1, op:2'd1, a:4'hF, b:4'h1, d:4'h0, f:1'b1};
        vecs[7] = '{c:1'b0, op:2'd2, a:4'h5, b:4'h5, d:4'h0, f:1'b0};

        rst = 1'b1;
        req0_valid = 1'b1; req0_op = 2'd1; req0_a = 4'h1; req0_b = 4'h1;
        req1_valid = 1'b0; req1_op = 2'd0; req1_a = 4'h0; req1_b = 4'h0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset req0_ready", {31'd0, req0_ready}, 32'd0);
        chk("reset rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset alu_op", {30'd0, alu_op}, 32'd0);
        chk("reset alu_a", {28'd0, alu_a}, 32'd0);
        chk("reset rsp1_data", {28'd0, rsp1_data}, 32'd0);
        req0_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post-reset busy", {31'd0, busy}, 32'd0);
        chk("post-reset grant", {31'd0, grant}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i], i);
        end

        // Response stall: client 0 holds rsp0_ready low while client 1 waits
        @(negedge clk);
        drive_req(1'b0, 2'd1, 4'h5, 4'h6);
        accept_req(1'b0, ok);
        drive_req(1'b1, 2'd1, 4'h1, 4'h2);
        n = 0;
        while (!rsp0_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall rsp0 arrives", {31'd0, rsp0_valid}, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            chk("stall rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
            chk("stall rsp0_data", {28'd0, rsp0_data}, 32'hB);
            chk("stall req1_ready", {31'd0, req1_ready}, 32'd0);
            chk("stall busy", {31'd0, busy}, 32'd1);
        end
        rsp0_ready = 1'b1;
        @(negedge clk);
        rsp0_ready = 1'b0;
        accept_req(1'b1, ok);
        n = 0;
        while (!rsp1_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stall rsp1 latency", n, 32'd2);
        chk("stall rsp1_data", {28'd0, rsp1_data}, 32'h3);
        rsp1_ready = 1'b1;
        @(negedge clk);
        rsp1_ready = 1'b0;

        // Reset pulsed while the transaction is in WAIT
        @(negedge clk);
        drive_req(1'b0, 2'd1, 4'h9, 4'h9);
        accept_req(1'b0, ok);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("midrst alu_op", {30'd0, alu_op}, 32'd0);
        chk("midrst alu_a", {28'd0, alu_a}, 32'd0);
        chk("midrst rsp0_data", {28'd0, rsp0_data}, 32'd0);
        @(negedge clk);
        chk("midrst held busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        run_txn('{c:1'b0, op:2'd1, a:4'h2, b:4'h3, d:4'h5, f:1'b0}, 100);

        // Contention: both clients request continuously with responses always accepted
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        drive_req(1'b0, 2'd1, 4'h1, 4'h1);
        drive_req(1'b1, 2'd1, 4'h2, 4'h2);
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        ng  = 0;
        cyc = 0;
        while (ng < 4 && cyc < 60) begin
            #1;
            if (req0_ready || req1_ready) begin
                chk("contend single ready", {31'd0, req0_ready & req1_ready}, 32'd0);
                g[ng] = req1_ready ? 1 : 0;
                t[ng] = cyc;
                ng++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("contend grants seen", ng, 32'd4);
        if (ng == 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
                chk($sformatf("contend grant%0d", k), g[k], k % 2);
`else
                chk($sformatf("contend grant%0d", k), g[k], 32'd0);
`endif
            end
            for (int k = 1; k < 4; k++) begin
                chk($sformatf("contend spacing%0d", k), t[k] - t[k-1], 32'd4);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("contend drained busy", {31'd0, busy}, 32'd0);
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
